// File: rtl/iir_pkg.sv
`default_nettype none
// ============================================================================
// Package     : iir_pkg
// Description : Shared constants for the IIR decimating output stage.
//               - default sample width and default decimation/FIFO sizes
//               - accumulator width helper (NB_DATA + LOG2_DEC, signed,
//                 wide enough that a full block never wraps)
// Revision    : 1.0 - initial release
// ============================================================================
package iir_pkg;

    localparam int c_nb_data_def    = 16;
    localparam int c_log2_dec_def   = 2;
    localparam int c_log2_depth_def = 2;

    // Sum of 2^log2_dec samples of nb_data bits needs log2_dec extra bits.
    function automatic int acc_width(input int nb_data, input int log2_dec);
        return nb_data + log2_dec;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : First-word-fall-through synchronous FIFO, 2^LOG2_DEPTH deep.
//               A push is accepted when not full, or when full and a pop
//               happens in the same cycle (count then stays at DEPTH).
//               A push that finds the FIFO full with no pop is discarded and
//               reported on o_drop for that cycle.
// Ports       : clock      - clock, rising edge
//               i_rst      - synchronous active-high reset
//               i_push     - write request
//               i_wdata    - write data
//               i_ready    - consumer accepts head entry (pop when o_valid)
//               o_data     - head entry
//               o_valid    - FIFO not empty
//               o_full     - FIFO holds DEPTH entries
//               o_drop     - current push is being discarded
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH      = 16,
    parameter int LOG2_DEPTH = 2
) (
    input  logic             clock,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_full,
    output logic             o_drop
);

    localparam int c_depth = 1 << LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] c_count_full = (LOG2_DEPTH+1)'(c_depth);

    logic [WIDTH-1:0]      r_mem [c_depth];
    logic [LOG2_DEPTH-1:0] r_wr_ptr;
    logic [LOG2_DEPTH-1:0] r_rd_ptr;
    logic [LOG2_DEPTH:0]   r_count;

    logic w_pop;
    logic w_wr_en;

    assign o_valid = (r_count != '0);
    assign o_full  = (r_count == c_count_full);
    assign o_data  = r_mem[r_rd_ptr];

    assign w_pop   = o_valid && i_ready;
    // When full, the slot freed by a same-cycle pop is the one being written.
    assign w_wr_en = i_push && (!o_full || w_pop);
    assign o_drop  = i_push && o_full && !w_pop;

    always_ff @(posedge clock) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + LOG2_DEPTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + LOG2_DEPTH'(1);
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + (LOG2_DEPTH+1)'(1);
                2'b01:   r_count <= r_count - (LOG2_DEPTH+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/iir_dec_out.sv
`default_nettype none
// ============================================================================
// Module      : iir_dec_out
// Description : Decimating output stage for the 16-bit IIR filter. Averages
//               each block of 2^LOG2_DEC valid samples into one result,
//               buffers results in a FWFT FIFO and delivers them over a
//               valid/ready handshake. o_overflow is sticky once a result is
//               dropped because the FIFO was full with no pop.
// Config      : ROUND_EN - when defined, DEC/2 is added before the arithmetic
//               shift (round half up); otherwise truncation toward -inf.
// Ports       : clock      - clock, rising edge
//               i_rst      - synchronous active-high reset
//               i_x        - filter sample, signed
//               i_valid    - i_x is a new sample
//               o_data     - decimated result at FIFO head, signed
//               o_valid    - o_data holds a result
//               i_ready    - downstream accepts o_data
//               o_overflow - sticky: at least one result dropped
// Revision    : 1.0 - initial release
// ============================================================================
module iir_dec_out
    import iir_pkg::*;
#(
    parameter int NB_DATA    = c_nb_data_def,
    parameter int LOG2_DEC   = c_log2_dec_def,
    parameter int LOG2_DEPTH = c_log2_depth_def
) (
    input  logic                      clock,
    input  logic                      i_rst,
    input  logic signed [NB_DATA-1:0] i_x,
    input  logic                      i_valid,
    output logic signed [NB_DATA-1:0] o_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic                      o_overflow
);

    localparam int c_acc_w = acc_width(NB_DATA, LOG2_DEC);
    localparam int c_dec   = 1 << LOG2_DEC;
    localparam logic [LOG2_DEC-1:0] c_last_phase = LOG2_DEC'(c_dec - 1);
`ifdef ROUND_EN
    localparam logic signed [c_acc_w-1:0] c_half = c_acc_w'(c_dec / 2);
`endif

    logic [LOG2_DEC-1:0]       r_phase;
    logic signed [c_acc_w-1:0] r_acc;
    logic                      r_overflow;

    logic signed [c_acc_w-1:0] w_sx;
    logic signed [c_acc_w-1:0] w_sum;
    logic signed [c_acc_w-1:0] w_rsum;
    logic [NB_DATA-1:0]        w_result;
    logic                      w_push;
    logic                      w_drop;
    logic                      w_full;
    logic [NB_DATA-1:0]        w_fifo_data;
    logic                      w_unused;

    assign w_sx  = {{LOG2_DEC{i_x[NB_DATA-1]}}, i_x};
    assign w_sum = r_acc + w_sx;

`ifdef ROUND_EN
    assign w_rsum = w_sum + c_half;
`else
    assign w_rsum = w_sum;
`endif

    // Taking bits above the LOG2_DEC fraction bits is exactly the arithmetic
    // shift truncated to NB_DATA; the mean of in-range samples always fits.
    assign w_result = w_rsum[LOG2_DEC +: NB_DATA];
    assign w_unused = ^w_rsum[LOG2_DEC-1:0] ^ w_full;

    assign w_push = i_valid && (r_phase == c_last_phase);

    always_ff @(posedge clock) begin
        if (i_rst) begin
            r_phase    <= '0;
            r_acc      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (i_valid) begin
                // Phase counter wraps naturally at DEC.
                r_phase <= r_phase + LOG2_DEC'(1);
                r_acc   <= (r_phase == '0) ? w_sx : w_sum;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH      (NB_DATA),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_wdata (w_result),
        .i_ready (i_ready),
        .o_data  (w_fifo_data),
        .o_valid (o_valid),
        .o_full  (w_full),
        .o_drop  (w_drop)
    );

    assign o_data     = w_fifo_data;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_iir_dec_out.sv
`default_nettype none
// ============================================================================
// Module      : tb_iir_dec_out
// Description : Self-checking bench for iir_dec_out. A queue-based model of
//               block averaging and the bounded result buffer is compared
//               against the DUT every cycle; directed scenarios add literal
//               expectations, followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iir_dec_out;

    localparam int NB    = 16;
    localparam int L2DEC = 2;
    localparam int DEC   = 1 << L2DEC;
    localparam int L2DEP = 2;
    localparam int DEPTH = 1 << L2DEP;
`ifdef ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    logic                  clock = 1'b0;
    logic                  rst;
    logic                  valid;
    logic                  ready;
    logic signed [NB-1:0]  x;
    logic signed [NB-1:0]  data;
    logic                  ovalid;
    logic                  ovf;

    always #5 clock = ~clock;

    iir_dec_out #(
        .NB_DATA    (NB),
        .LOG2_DEC   (L2DEC),
        .LOG2_DEPTH (L2DEP)
    ) dut (
        .clock      (clock),
        .i_rst      (rst),
        .i_x        (x),
        .i_valid    (valid),
        .o_data     (data),
        .o_valid    (ovalid),
        .i_ready    (ready),
        .o_overflow (ovf)
    );

    int tests = 0;
    int fails = 0;

    // Model state: pending results, samples of the current block, sticky flag.
    int m_q[$];
    int m_blk[$];
    bit m_ovf  = 1'b0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Mean of a block: floor((sum + rounding) / DEC), computed arithmetically.
    function automatic int mean_of(input int s);
        int d;
        int r;
        d = s + (RND != 0 ? DEC / 2 : 0);
        r = d / DEC;
        if ((d % DEC) != 0 && d < 0) r = r - 1;
        return r;
    endfunction

    // Drive one cycle's inputs, advance the model, wait until just after the
    // next falling edge (DUT outputs settled for the new state).
    task automatic cyc(input bit r, input bit v, input int xv, input bit rd);
        int xs;
        int s;
        bit pop;
        rst   = r;
        valid = v;
        x     = NB'(xv);
        ready = rd;
        xs    = x;
        if (r) begin
            m_q.delete();
            m_blk.delete();
            m_ovf = 1'b0;
        end else begin
            pop = (m_q.size() != 0) && rd;
            if (pop) void'(m_q.pop_front());
            if (v) begin
                m_blk.push_back(xs);
                if (m_blk.size() == DEC) begin
                    s = 0;
                    foreach (m_blk[i]) s += m_blk[i];
                    m_blk.delete();
                    if (m_q.size() < DEPTH) m_q.push_back(mean_of(s));
                    else m_ovf = 1'b1;
                end
            end
        end
        chk_en = 1'b1;
        @(negedge clock);
        #1;
    endtask

    task automatic feed(input int xv, input bit rd);
        cyc(1'b0, 1'b1, xv, rd);
    endtask

    task automatic idle(input bit rd);
        cyc(1'b0, 1'b0, 0, rd);
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("o_valid", int'(ovalid), int'(m_q.size() != 0));
            if (m_q.size() != 0) chk("o_data", int'(data), m_q[0]);
            chk("o_overflow", int'(ovf), int'(m_ovf));
        end
    end

    initial begin
        int thresh;
        int xv;
        rst = 1'b1; valid = 1'b0; ready = 1'b0; x = '0;
        @(negedge clock);
        #1;
        cyc(1'b1, 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b0);
        chk("reset_o_valid", int'(ovalid), 0);
        chk("reset_o_data", int'(data), 0);
        chk("reset_o_overflow", int'(ovf), 0);

        // Basic average: 4,8,12,16 -> 10, valid for exactly one cycle.
        feed(4, 1'b1); feed(8, 1'b1); feed(12, 1'b1);
        chk("basic_no_early_valid", int'(ovalid), 0);
        feed(16, 1'b1);
        chk("basic_valid", int'(ovalid), 1);
        chk("basic_data", int'(data), 10);
        idle(1'b1);
        chk("basic_one_cycle", int'(ovalid), 0);

        // Negative rounding case: sum -5.
        chk("model_mean_neg5", mean_of(-5), (RND != 0) ? -1 : -2);
        feed(-1, 1'b1); feed(-1, 1'b1); feed(-1, 1'b1); feed(-2, 1'b1);
        chk("neg_data", int'(data), (RND != 0) ? -1 : -2);
        idle(1'b1);

        // Range extremes.
        for (int i = 0; i < 4; i++) feed(32767, 1'b1);
        chk("max_data", int'(data), 32767);
        idle(1'b1);
        for (int i = 0; i < 4; i++) feed(-32768, 1'b1);
        chk("min_data", int'(data), -32768);
        chk("extreme_no_overflow", int'(ovf), 0);
        idle(1'b1);

        // Overflow: 5 blocks with no consumer.
        cyc(1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            feed(5, 1'b0);
            if (i == 15) chk("ovf_after_4_blocks", int'(ovf), 0);
        end
        chk("ovf_after_5th_block", int'(ovf), 1);
        for (int i = 0; i < 4; i++) begin
            chk("ovf_drain_valid", int'(ovalid), 1);
            chk("ovf_drain_data", int'(data), 5);
            idle(1'b1);
        end
        chk("ovf_drained_empty", int'(ovalid), 0);
        chk("ovf_sticky", int'(ovf), 1);

        // Full FIFO with simultaneous pop when a block completes.
        cyc(1'b1, 1'b0, 0, 1'b0);
        for (int k = 1; k <= 4; k++)
            for (int i = 0; i < 4; i++) feed(k, 1'b0);
        feed(5, 1'b0); feed(5, 1'b0); feed(5, 1'b0);
        feed(5, 1'b1);
        chk("fullpop_no_overflow", int'(ovf), 0);
        for (int e = 2; e <= 5; e++) begin
            chk("fullpop_order", int'(data), e);
            idle(1'b1);
        end
        chk("fullpop_empty", int'(ovalid), 0);
        chk("fullpop_ovf_clear", int'(ovf), 0);

        // Reset mid-block, then a block with gaps.
        feed(100, 1'b1); feed(100, 1'b1);
        cyc(1'b1, 1'b0, 0, 1'b1);
        feed(8, 1'b1); idle(1'b1); feed(8, 1'b1); idle(1'b1); idle(1'b1);
        feed(8, 1'b1);
        chk("midrst_no_early_valid", int'(ovalid), 0);
        feed(8, 1'b1);
        chk("midrst_valid", int'(ovalid), 1);
        chk("midrst_data", int'(data), 8);
        idle(1'b1);
        chk("midrst_single", int'(ovalid), 0);

        // Randomized traffic with varying consumer back-pressure.
        thresh = 70;
        for (int n = 0; n < 3000; n++) begin
            if ((n % 500) == 0) thresh = $urandom_range(5, 95);
            if ($urandom_range(0, 9) == 0)
                xv = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
            else
                xv = int'($urandom_range(0, 65535)) - 32768;
            cyc($urandom_range(0, 299) == 0,
                $urandom_range(0, 3) != 0,
                xv,
                int'($urandom_range(0, 99)) < thresh);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
